// File: rtl/i2c_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : i2c_arbiter
// Purpose  : Round-robin arbiter that shares one I2C master between
//            NUM_REQ requesters. A granted request is latched and launched
//            with a single m_start pulse. The owner then receives one
//            completion pulse, either on m_done or on a watchdog timeout
//            (the timeout also aborts the master). A fixed bus-free gap
//            follows every transaction.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   req_valid    per-requester request
//   req_addr     packed 7-bit addresses, requester i at [7i+6:7i]
//   req_data     packed write bytes, requester i at [8i+7:8i]
//   req_ready    one-hot, 1-cycle accept pulse
//   rsp_valid    one-hot, 1-cycle completion pulse to the owner
//   rsp_nack     slave NACK status, qualified by rsp_valid
//   rsp_timeout  watchdog timeout status, qualified by rsp_valid
//   m_start      1-cycle start pulse to the master
//   m_abort      1-cycle abort pulse to the master (forces STOP)
//   m_addr       latched address to the master
//   m_data       latched write byte to the master
//   m_busy       master busy; no grant is made while it is high
//   m_done       1-cycle pulse at the end of a master transaction
//   m_nack       master NACK status, valid with m_done
//   owner_id     index of the current or last granted requester
//   arb_busy     high in every state except IDLE
// ============================================================================
module i2c_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int GAP_CYCLES     = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*7-1:0]       req_addr,
  input  logic [NUM_REQ*8-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic                       rsp_nack,
  output logic                       rsp_timeout,
  output logic                       m_start,
  output logic                       m_abort,
  output logic [6:0]                 m_addr,
  output logic [7:0]                 m_data,
  input  logic                       m_busy,
  input  logic                       m_done,
  input  logic                       m_nack,
  output logic [$clog2(NUM_REQ)-1:0] owner_id,
  output logic                       arb_busy
);

  localparam int ID_W    = $clog2(NUM_REQ);
  // One counter serves both the WAIT watchdog and the GAP timer.
  localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
  localparam logic [ID_W-1:0]  LAST_ID      = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [ID_W-1:0]     rr_ptr, rr_ptr_nxt, owner_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [NUM_REQ-1:0]  req_ready_nxt, rsp_valid_nxt;
  logic                rsp_nack_nxt, rsp_timeout_nxt, m_start_nxt, m_abort_nxt;
  logic [6:0]          m_addr_nxt;
  logic [7:0]          m_data_nxt;

  logic [6:0]          addr_arr [NUM_REQ];
  logic [7:0]          data_arr [NUM_REQ];

  logic                found;
  logic [ID_W-1:0]     winner;

  generate
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign addr_arr[g] = req_addr[7*g +: 7];
      assign data_arr[g] = req_data[8*g +: 8];
    end
  endgenerate

  // Round-robin search: the first active requester at or above rr_ptr,
  // wrapping around to index 0.
  always_comb begin
    int              idx;
    logic [ID_W-1:0] cand;
    found  = 1'b0;
    winner = rr_ptr;
    idx    = 0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx  = (int'(rr_ptr) + k) % NUM_REQ;
      cand = ID_W'(idx);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Next state and next registered outputs. Every output is registered so
  // that the asynchronous reset alone forces it to zero.
  always_comb begin
    state_nxt       = state;
    rr_ptr_nxt      = rr_ptr;
    owner_nxt       = owner_id;
    cnt_nxt         = cnt;
    req_ready_nxt   = '0;
    rsp_valid_nxt   = '0;
    rsp_nack_nxt    = 1'b0;
    rsp_timeout_nxt = 1'b0;
    m_start_nxt     = 1'b0;
    m_abort_nxt     = 1'b0;
    m_addr_nxt      = m_addr;
    m_data_nxt      = m_data;

    case (state)
      ST_IDLE: begin
        if (found && !m_busy) begin
          req_ready_nxt = NUM_REQ'(1) << winner;
          m_addr_nxt    = addr_arr[winner];
          m_data_nxt    = data_arr[winner];
          owner_nxt     = winner;
          rr_ptr_nxt    = (winner == LAST_ID) ? '0 : winner + ID_W'(1);
          state_nxt     = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        m_start_nxt = 1'b1;
        cnt_nxt     = '0;
        state_nxt   = ST_WAIT;
      end

      ST_WAIT: begin
        // m_done is tested first so a completion on the expiry cycle wins.
        if (m_done) begin
          rsp_valid_nxt = NUM_REQ'(1) << owner_id;
          rsp_nack_nxt  = m_nack;
          cnt_nxt       = '0;
          state_nxt     = ST_GAP;
        end else if (cnt == TIMEOUT_LAST) begin
          rsp_valid_nxt   = NUM_REQ'(1) << owner_id;
          rsp_timeout_nxt = 1'b1;
          m_abort_nxt     = 1'b1;
          cnt_nxt         = '0;
          state_nxt       = ST_GAP;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      owner_id    <= '0;
      cnt         <= '0;
      req_ready   <= '0;
      rsp_valid   <= '0;
      rsp_nack    <= 1'b0;
      rsp_timeout <= 1'b0;
      m_start     <= 1'b0;
      m_abort     <= 1'b0;
      m_addr      <= '0;
      m_data      <= '0;
    end else begin
      state       <= state_nxt;
      rr_ptr      <= rr_ptr_nxt;
      owner_id    <= owner_nxt;
      cnt         <= cnt_nxt;
      req_ready   <= req_ready_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_nack    <= rsp_nack_nxt;
      rsp_timeout <= rsp_timeout_nxt;
      m_start     <= m_start_nxt;
      m_abort     <= m_abort_nxt;
      m_addr      <= m_addr_nxt;
      m_data      <= m_data_nxt;
    end
  end

  assign arb_busy = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning the number of requester ports (legal 2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096, meaning the maximum clk cycles spent waiting for m_done.
REQ-003 SHALL have parameter GAP_CYCLES, default 64, meaning the bus-free clk cycles between transactions (legal >=1).
REQ-004 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port req_valid, input, NUM_REQ, per-requester transaction request.
REQ-007 SHALL have port req_addr, input, NUM_REQ*7, 7-bit device address per requester (requester i at bits [7i+6:7i]).
REQ-008 SHALL have port req_data, input, NUM_REQ*8, write byte per requester (requester i at bits [8i+7:8i]).
REQ-009 SHALL have port req_ready, output, NUM_REQ, one-hot 1-cycle accept pulse.
REQ-010 SHALL have port rsp_valid, output, NUM_REQ, one-hot 1-cycle completion pulse to the owning requester.
REQ-011 SHALL have port rsp_nack, output, 1, slave NACK status, qualified by any rsp_valid bit.
REQ-012 SHALL have port rsp_timeout, output, 1, timeout status, qualified by any rsp_valid bit.
REQ-013 SHALL have port m_start, output, 1, 1-cycle start pulse to the I2C master.
REQ-014 SHALL have port m_abort, output, 1, 1-cycle abort pulse to the I2C master (forces STOP).
REQ-015 SHALL have port m_addr, output, 7, latched address to the master.
REQ-016 SHALL have port m_data, output, 8, latched write byte to the master.
REQ-017 SHALL have port m_busy, input, 1, master busy.
REQ-018 SHALL have port m_done, input, 1, 1-cycle pulse at master transaction end.
REQ-019 SHALL have port m_nack, input, 1, master NACK status, valid with m_done.
REQ-020 SHALL have port owner_id, output, clog2(NUM_REQ), index of the current/last granted requester.
REQ-021 SHALL have port arb_busy, output, 1, high in every state except IDLE.

Function
REQ-022 SHALL implement states IDLE, ISSUE, WAIT and GAP.
REQ-023 SHALL in IDLE, when any req_valid is high and m_busy=0, select the winner round-robin from index rr_ptr upward with wrap-around, pulse req_ready[winner], latch its addr/data into m_addr/m_data, set owner_id, and go to ISSUE next cycle.
REQ-024 SHALL set rr_ptr to (winner+1) mod NUM_REQ on each grant.
REQ-025 SHALL stay in IDLE while m_busy=1, with req_ready all zero.
REQ-026 SHALL in ISSUE assert m_start for exactly one cycle, clear the timeout counter, and enter WAIT (grant-to-m_start latency exactly 1 cycle).
REQ-027 SHALL in WAIT increment the timeout counter each cycle; on m_done, pulse rsp_valid[owner_id] with rsp_nack=m_nack and rsp_timeout=0, then enter GAP.
REQ-028 SHALL in WAIT, when the counter reaches TIMEOUT_CYCLES-1 with no m_done, pulse m_abort and rsp_valid[owner_id] with rsp_timeout=1 and rsp_nack=0, then enter GAP.
REQ-029 SHALL give m_done priority if m_done and timeout expiry occur in the same cycle.
REQ-030 SHALL ignore m_done outside WAIT.
REQ-031 SHALL in GAP count GAP_CYCLES cycles, then return to IDLE; no grant is made during GAP.
REQ-032 SHALL hold m_addr/m_data stable from ISSUE through GAP.
REQ-033 SHALL not require a requester to drop req_valid after req_ready; a still-high req_valid is a new request.

Reset
REQ-034 SHALL on rst_n low immediately force IDLE, rr_ptr=0, owner_id=0, counters=0, and all outputs (req_ready, rsp_valid, rsp_nack, rsp_timeout, m_start, m_abort, m_addr, m_data, arb_busy) to 0, including mid-transaction; no rsp_valid is issued for an aborted transaction.

Verification
REQ-035 SHALL verify: req_valid=4'b0001, addr 0x50, data 0xA5, m_done after 20 cycles with m_nack=0 -> req_ready[0], then m_start with m_addr=0x50 and m_data=0xA5, then rsp_valid[0] with nack=0, then GAP of 64 cycles.
REQ-036 SHALL verify: req_valid=4'b1111 held high -> grants in order 0,1,2,3,0, each separated by at least GAP_CYCLES.
REQ-037 SHALL verify: m_done with m_nack=1 -> rsp_valid[owner] with rsp_nack=1 and rsp_timeout=0.
REQ-038 SHALL verify: no m_done for 4096 cycles -> m_abort and rsp_valid with rsp_timeout=1; m_done on the expiry cycle -> normal completion and no m_abort.
REQ-039 SHALL verify: m_busy=1 in IDLE with req_valid=4'b0010 -> no grant until m_busy falls.
REQ-040 SHALL verify: rst_n asserted in WAIT -> all outputs 0 asynchronously; after release, the first grant starts from index 0.
